// File: rtl/knn_pkg.sv
// Shared definitions for the k-nearest-neighbour classifier: controller state
// encoding and the class-count derivation used wherever TYPE_W appears.
package knn_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_VOTE    = 2'd2,
        S_DONE    = 2'd3
    } knn_state_t;

    function automatic int num_types(input int type_w);
        return 1 << type_w;
    endfunction

endpackage

// File: rtl/knn_sorted_list.sv
// K-deep list of {distance, label} kept in ascending distance order; one
// insertion per cycle, ties keep the earlier arrival ahead of the newcomer.
module knn_sorted_list
    import knn_pkg::*;
#(
    parameter int K      = 3,
    parameter int W      = 8,
    parameter int TYPE_W = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       insert,
    input  logic [2*W-1:0]             distance,
    input  logic [TYPE_W-1:0]          data_type,
    output logic [K-1:0][2*W-1:0]      entry_dist,
    output logic [K-1:0][TYPE_W-1:0]   entry_type,
    output logic [K-1:0]               entry_valid
);

    // Valid entries are always packed at the front, so this mask is
    // monotonic: zeros for slots that stay put, ones from the insert point on.
    logic [K-1:0] after;

    always_comb begin
        after = '0;
        for (int i = 0; i < K; i++) begin
            after[i] = !entry_valid[i] || (entry_dist[i] > distance);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int i = 0; i < K; i++) begin
                entry_dist[i]  <= '1;
                entry_type[i]  <= '0;
                entry_valid[i] <= 1'b0;
            end
        end else if (insert) begin
            if (after[0]) begin
                entry_dist[0]  <= distance;
                entry_type[0]  <= data_type;
                entry_valid[0] <= 1'b1;
            end
            for (int i = 1; i < K; i++) begin
                if (after[i]) begin
                    if (!after[i-1]) begin
                        entry_dist[i]  <= distance;
                        entry_type[i]  <= data_type;
                        entry_valid[i] <= 1'b1;
                    end else begin
                        entry_dist[i]  <= entry_dist[i-1];
                        entry_type[i]  <= entry_type[i-1];
                        entry_valid[i] <= entry_valid[i-1];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/knn_selector.sv
// k-NN selector: collects N_TRAIN labelled distances, keeps the K nearest,
// then votes one class per cycle and reports the majority label.
module knn_selector
    import knn_pkg::*;
#(
    parameter int K       = 3,
    parameter int W       = 8,
    parameter int TYPE_W  = 2,
    parameter int N_TRAIN = 5
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic [2*W-1:0]                        distance,
    input  logic [TYPE_W-1:0]                     data_type,
    input  logic                                  done,
    output logic                                  next_sample,
    output logic [TYPE_W-1:0]                     result_type,
    output logic                                  result_valid,
    output logic                                  busy,
    output knn_state_t                            state,
    output logic [$clog2(N_TRAIN+1)-1:0]          sample_count,
    output logic [K-1:0][2*W-1:0]                 entry_dist,
    output logic [K-1:0][TYPE_W-1:0]              entry_type,
    output logic [K-1:0]                          entry_valid
);

    localparam int NUM_TYPES = num_types(TYPE_W);
    localparam int CNT_W     = $clog2(N_TRAIN + 1);
    localparam int VOTE_W    = $clog2(K + 1);

    logic              list_clear;
    logic              list_insert;
    logic [TYPE_W-1:0] cls;
    logic [VOTE_W-1:0] vote_count;
    logic [VOTE_W-1:0] best_count;
    logic [TYPE_W-1:0] best_type;
    logic              last_cls;
    logic              new_best;

    // Handshake: start and done are single-cycle qualifiers sampled on the
    // rising edge; next_sample and result_valid are single-cycle registered
    // pulses. start wins over a coincident done while collecting.
    assign list_clear  = start && (state == S_IDLE || state == S_COLLECT);
    assign list_insert = done && !start && (state == S_COLLECT);
    assign busy        = (state != S_IDLE);

    knn_sorted_list #(
        .K      (K),
        .W      (W),
        .TYPE_W (TYPE_W)
    ) u_list (
        .clk         (clk),
        .rst         (rst),
        .clear       (list_clear),
        .insert      (list_insert),
        .distance    (distance),
        .data_type   (data_type),
        .entry_dist  (entry_dist),
        .entry_type  (entry_type),
        .entry_valid (entry_valid)
    );

    always_comb begin
        vote_count = '0;
        for (int i = 0; i < K; i++) begin
            if (entry_valid[i] && entry_type[i] == cls) begin
                vote_count = vote_count + VOTE_W'(1);
            end
        end
    end

    assign last_cls = (cls == TYPE_W'(NUM_TYPES - 1));
    // Strict comparison keeps the lowest class index on ties.
    assign new_best = (vote_count > best_count);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            sample_count <= '0;
            next_sample  <= 1'b0;
            result_valid <= 1'b0;
            result_type  <= '0;
            cls          <= '0;
            best_count   <= '0;
            best_type    <= '0;
        end else begin
            next_sample  <= 1'b0;
            result_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        sample_count <= '0;
                        next_sample  <= 1'b1;
                        state        <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (start) begin
                        sample_count <= '0;
                        next_sample  <= 1'b1;
                    end else if (done) begin
                        sample_count <= sample_count + CNT_W'(1);
                        if (sample_count == CNT_W'(N_TRAIN - 1)) begin
                            state      <= S_VOTE;
                            cls        <= '0;
                            best_count <= '0;
                            best_type  <= '0;
                        end else begin
                            next_sample <= 1'b1;
                        end
                    end
                end
                S_VOTE: begin
                    if (new_best) begin
                        best_count <= vote_count;
                        best_type  <= cls;
                    end
                    cls <= cls + TYPE_W'(1);
                    if (last_cls) begin
                        result_type  <= new_best ? cls : best_type;
                        result_valid <= 1'b1;
                        state        <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_knn_selector.sv
// Directed and randomized checks of knn_selector against a selection-sort
// reference of the K nearest samples and a plurality vote.
module tb_knn_selector;
    import knn_pkg::*;

    localparam int K  = 3;
    localparam int W  = 8;
    localparam int TW = 2;
    localparam int NT = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst, start, done;
    logic [2*W-1:0]         distance;
    logic [TW-1:0]          data_type;
    logic                   next_sample, result_valid, busy;
    logic [TW-1:0]          result_type;
    knn_state_t             state;
    logic [2:0]             sample_count;
    logic [K-1:0][2*W-1:0]  entry_dist;
    logic [K-1:0][TW-1:0]   entry_type;
    logic [K-1:0]           entry_valid;

    logic                   start_b, done_b;
    logic [2*W-1:0]         distance_b;
    logic [TW-1:0]          type_b;
    logic                   next_sample_b, result_valid_b, busy_b;
    logic [TW-1:0]          result_type_b;
    knn_state_t             state_b;
    logic [1:0]             sample_count_b;
    logic [K-1:0][2*W-1:0]  entry_dist_b;
    logic [K-1:0][TW-1:0]   entry_type_b;
    logic [K-1:0]           entry_valid_b;

    knn_selector #(.K(K), .W(W), .TYPE_W(TW), .N_TRAIN(NT)) dut (
        .clk(clk), .rst(rst), .start(start), .distance(distance),
        .data_type(data_type), .done(done), .next_sample(next_sample),
        .result_type(result_type), .result_valid(result_valid), .busy(busy),
        .state(state), .sample_count(sample_count), .entry_dist(entry_dist),
        .entry_type(entry_type), .entry_valid(entry_valid)
    );

    knn_selector #(.K(K), .W(W), .TYPE_W(TW), .N_TRAIN(2)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .distance(distance_b),
        .data_type(type_b), .done(done_b), .next_sample(next_sample_b),
        .result_type(result_type_b), .result_valid(result_valid_b), .busy(busy_b),
        .state(state_b), .sample_count(sample_count_b), .entry_dist(entry_dist_b),
        .entry_type(entry_type_b), .entry_valid(entry_valid_b)
    );

    int checks = 0;
    int failures = 0;
    int sd[$];
    int st[$];
    int exp_d[K];
    int exp_t[K];
    int exp_v[K];
    int exp_res;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: the K nearest samples, earliest arrival first among equal
    // distances, then the label with the strictly largest count (lowest wins ties).
    task automatic build_model();
        int used[$];
        int votes[4];
        int best;
        used = {};
        for (int i = 0; i < sd.size(); i++) used.push_back(0);
        for (int c = 0; c < 4; c++) votes[c] = 0;
        for (int s = 0; s < K; s++) begin
            best = -1;
            for (int i = 0; i < sd.size(); i++) begin
                if (used[i] == 0 && (best < 0 || sd[i] < sd[best])) best = i;
            end
            if (best >= 0) begin
                used[best] = 1;
                exp_d[s] = sd[best];
                exp_t[s] = st[best];
                exp_v[s] = 1;
                votes[st[best]]++;
            end else begin
                exp_d[s] = 16'hffff;
                exp_t[s] = 0;
                exp_v[s] = 0;
            end
        end
        exp_res = 0;
        for (int c = 1; c < 4; c++) if (votes[c] > votes[exp_res]) exp_res = c;
    endtask

    task automatic feed(input int d, input int t, input bit last, input string name);
        int n;
        n = 0;
        while (!next_sample && n < 20) begin step(); n++; end
        check({name, "_ns_seen"}, next_sample, 1);
        repeat ($urandom_range(0, 2)) step();
        done = 1'b1;
        distance = 16'(d);
        data_type = 2'(t);
        sd.push_back(d);
        st.push_back(t);
        step();
        done = 1'b0;
        check({name, "_ns_after_done"}, next_sample, last ? 0 : 1);
    endtask

    task automatic finish_case(input int dl[NT], input int tl[NT], input string name);
        int n;
        for (int i = 0; i < NT; i++) feed(dl[i], tl[i], i == NT - 1, name);
        check({name, "_state_vote"}, state, S_VOTE);
        build_model();
        for (int i = 0; i < K; i++) begin
            check($sformatf("%s_valid%0d", name, i), entry_valid[i], exp_v[i]);
            check($sformatf("%s_dist%0d", name, i), entry_dist[i], exp_d[i]);
            check($sformatf("%s_type%0d", name, i), entry_type[i], exp_t[i]);
        end
        n = 0;
        while (!result_valid && n < 20) begin step(); n++; end
        check({name, "_latency"}, n, 4);
        check({name, "_result"}, result_type, exp_res);
        check({name, "_state_done"}, state, S_DONE);
        step();
        check({name, "_rv_low"}, result_valid, 0);
        check({name, "_idle"}, state, S_IDLE);
        check({name, "_busy_low"}, busy, 0);
        check({name, "_hold"}, result_type, exp_res);
    endtask

    task automatic run_case(input int dl[NT], input int tl[NT], input string name);
        sd = {};
        st = {};
        start = 1'b1;
        step();
        start = 1'b0;
        check({name, "_busy"}, busy, 1);
        check({name, "_collect"}, state, S_COLLECT);
        finish_case(dl, tl, name);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int dl[NT];
        int tl[NT];
        int n;
        int seen;
        rst = 1'b1; start = 1'b0; done = 1'b0; distance = '0; data_type = '0;
        start_b = 1'b0; done_b = 1'b0; distance_b = '0; type_b = '0;
        repeat (3) step();
        check("rst_state", state, S_IDLE);
        check("rst_busy", busy, 0);
        check("rst_ns", next_sample, 0);
        check("rst_rv", result_valid, 0);
        check("rst_rt", result_type, 0);
        check("rst_count", sample_count, 0);
        check("rst_valid", entry_valid, 0);
        check("rst_dist2", entry_dist[2], 16'hffff);
        check("rst_type0", entry_type[0], 0);
        rst = 1'b0;
        step();

        dl = '{50, 10, 30, 20, 40}; tl = '{0, 1, 1, 2, 0};
        run_case(dl, tl, "basic");
        check("basic_const", result_type, 1);

        dl = '{5, 6, 7, 90, 91}; tl = '{2, 1, 0, 3, 3};
        run_case(dl, tl, "tie");
        check("tie_const", result_type, 0);

        dl = '{10, 10, 10, 10, 10}; tl = '{3, 1, 1, 0, 2};
        run_case(dl, tl, "stable");
        check("stable_const", result_type, 1);
        check("stable_first", entry_type[0], 3);

        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < NT; i++) begin
                dl[i] = $urandom_range(0, 40);
                tl[i] = $urandom_range(0, 3);
            end
            run_case(dl, tl, $sformatf("rand%0d", r));
        end

        // Restart mid-collection with a coincident done.
        sd = {}; st = {};
        start = 1'b1; step(); start = 1'b0;
        feed(33, 1, 1'b0, "restart_pre");
        feed(12, 2, 1'b0, "restart_pre");
        start = 1'b1; done = 1'b1; distance = 16'd3; data_type = 2'd3;
        step();
        start = 1'b0; done = 1'b0;
        check("restart_valid", entry_valid, 0);
        check("restart_count", sample_count, 0);
        check("restart_ns", next_sample, 1);
        check("restart_state", state, S_COLLECT);
        sd = {}; st = {};
        dl = '{25, 15, 35, 5, 45}; tl = '{2, 3, 3, 0, 1};
        finish_case(dl, tl, "restart");

        // Reset in the second VOTE cycle.
        sd = {}; st = {};
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < NT; i++) feed(i + 1, 1, i == NT - 1, "midrst");
        check("midrst_vote", state, S_VOTE);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_idle", state, S_IDLE);
        check("midrst_busy", busy, 0);
        check("midrst_rv", result_valid, 0);
        seen = 0;
        repeat (8) begin step(); if (result_valid) seen = 1; end
        check("midrst_no_result", seen, 0);
        done = 1'b1; distance = 16'($urandom_range(0, 255)); data_type = 2'($urandom_range(0, 3));
        step();
        done = 1'b0;
        check("idle_done_ns", next_sample, 0);
        check("idle_done_busy", busy, 0);
        step();
        check("idle_done_ns2", next_sample, 0);
        check("idle_done_count", sample_count, 0);

        // Fewer samples than K on the N_TRAIN=2 instance.
        sd = '{8, 4}; st = '{3, 2};
        build_model();
        start_b = 1'b1; step(); start_b = 1'b0;
        check("n2_ns0", next_sample_b, 1);
        done_b = 1'b1; distance_b = 16'd8; type_b = 2'd3; step(); done_b = 1'b0;
        check("n2_ns1", next_sample_b, 1);
        done_b = 1'b1; distance_b = 16'd4; type_b = 2'd2; step(); done_b = 1'b0;
        check("n2_ns2", next_sample_b, 0);
        check("n2_vote", state_b, S_VOTE);
        for (int i = 0; i < K; i++) begin
            check($sformatf("n2_valid%0d", i), entry_valid_b[i], exp_v[i]);
            check($sformatf("n2_dist%0d", i), entry_dist_b[i], exp_d[i]);
            check($sformatf("n2_type%0d", i), entry_type_b[i], exp_t[i]);
        end
        check("n2_slot2_invalid", entry_valid_b[2], 0);
        n = 0;
        while (!result_valid_b && n < 20) begin step(); n++; end
        check("n2_latency", n, 4);
        check("n2_result", result_type_b, exp_res);
        check("n2_const", result_type_b, 2);
        step();
        check("n2_rv_low", result_valid_b, 0);
        check("n2_idle", busy_b, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/knn_selector.md
KNN_SELECTOR -- requirements
Module: knn_selector

Interface
REQ-001 SHALL have parameter K, default 3: number of nearest neighbours retained.
REQ-002 SHALL have parameter W, default 8: feature element width; distances are 2*W wide.
REQ-003 SHALL have parameter TYPE_W, default 2: class label width; NUM_TYPES = 2**TYPE_W.
REQ-004 SHALL have parameter N_TRAIN, default 5: training samples per classification.
REQ-005 SHALL have port clk, input, 1: single clock; all logic rising-edge.
REQ-006 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port start, input, 1: one-cycle pulse that begins a new classification.
REQ-008 SHALL have port distance, input, 2*W: squared distance from the upstream distance calculator.
REQ-009 SHALL have port data_type, input, TYPE_W: class label paired with distance.
REQ-010 SHALL have port done, input, 1: one-cycle pulse qualifying distance and data_type.
REQ-011 SHALL have port next_sample, output, 1: one-cycle pulse telling the upstream stage to compute the next distance.
REQ-012 SHALL have port result_type, output, TYPE_W: winning class.
REQ-013 SHALL have port result_valid, output, 1: one-cycle pulse qualifying result_type.
REQ-014 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-015 SHALL implement states IDLE, COLLECT, VOTE and DONE.
REQ-016 IDLE: on start, SHALL clear all K entries to invalid, clear the sample count, go to COLLECT, and pulse next_sample in the following cycle.
REQ-017 COLLECT: each done SHALL insert {distance, data_type} into a list sorted by ascending distance in one cycle, then increment the sample count.
REQ-018 Insertion SHALL place the new entry before the first valid entry with strictly greater distance; equal distances keep the earlier arrival first.
REQ-019 Insertion SHALL shift later entries down one slot, drop the entry in slot K-1, and discard the new sample if it is not smaller than a full list's slot K-1.
REQ-020 After each accepted done with count < N_TRAIN, SHALL pulse next_sample exactly one cycle later.
REQ-021 When the count reaches N_TRAIN, SHALL enter VOTE on the next cycle without pulsing next_sample.
REQ-022 VOTE: SHALL evaluate one class per cycle, class 0 to NUM_TYPES-1, counting the valid entries carrying that label; VOTE lasts exactly NUM_TYPES cycles.
REQ-023 Only valid entries SHALL be counted; when N_TRAIN < K, the unfilled slots are excluded.
REQ-024 The winner SHALL be the class with the strictly highest count; ties go to the lowest class index.
REQ-025 DONE: SHALL drive result_type, pulse result_valid for one cycle, then return to IDLE.
REQ-026 result_type SHALL hold its value until the next DONE or reset.
REQ-027 done SHALL be ignored in IDLE, VOTE and DONE.
REQ-028 start SHALL be ignored outside IDLE and COLLECT.
REQ-029 start in COLLECT SHALL clear the list and count, restart COLLECT, and take priority over a simultaneous done.
REQ-030 The sample count SHALL be $clog2(N_TRAIN+1) bits wide.
REQ-031 Vote counters SHALL be $clog2(K+1) bits wide; the distance compare SHALL be unsigned, 2*W bits.

Reset
REQ-032 While rst is high, SHALL force state IDLE and all entries invalid, with distance all-ones and type 0.
REQ-033 While rst is high, SHALL force count 0, next_sample 0, result_valid 0, result_type 0 and busy 0.
REQ-034 rst SHALL take effect in any state, including mid-COLLECT and mid-VOTE; no partial result may be emitted afterwards.

Structure
REQ-035 Shared package knn_pkg SHALL hold the state encoding and the NUM_TYPES derivation, shared with the distance calculator's TYPE_W usage.
REQ-036 The sorted insertion list SHALL be a sub-module knn_sorted_list (parameters K, W, TYPE_W) with clear/insert inputs and entry/valid outputs.

Verification (K=3, W=8, TYPE_W=2, N_TRAIN=5 unless stated)
REQ-037 Distances 50,10,30,20,40 with types 0,1,1,2,0 -> list 10/1, 20/2, 30/1; result_type=1, result_valid high exactly 4 cycles after VOTE entry.
REQ-038 Distances 5/2, 6/1, 7/0, 90/3, 91/3 -> counts all 1 -> tie-break gives result_type=0.
REQ-039 Five distances of 10 with types 3,1,1,0,2 -> stable order keeps 3,1,1; result_type=1.
REQ-040 Two samples, then start with a simultaneous done -> list empty, count 0, next_sample pulse, done ignored.
REQ-041 rst asserted in the 2nd VOTE cycle -> next cycle IDLE, busy=0, result_valid never pulses; done in IDLE -> no next_sample, busy stays 0.
REQ-042 Instance with N_TRAIN=2, samples 8/3, 4/2 -> slot 2 invalid, counts 2:1, 3:1; result_type=2.
